multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised multi-cycle RISC-V (RV32I subset) control unit, the successor to the single-cycle controller. It replaces the one-shot main/ALU decode with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles for a shared-memory datapath. It adds a memory ready handshake with a bounded wait timeout, all six conditional branches, JALR with link, and a sticky fault state for illegal encodings. It sits between the instruction register and datapath flags on one side and the multi-cycle datapath muxes and enables on the other.

## Interface
- ALU_CTRL_W, 4: width of alu_ctrl; must be >= 4.
- WAIT_LIMIT, 15: maximum stalled cycles per memory access; 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  opcode from the instruction register.
- func3  in  3  instruction bits [14:12].
- func7_5  in  1  instruction bit 30.
- zero, lt, ltu  in  1 each  ALU flags: result == 0, signed rs1 < rs2, unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_write, ir_write, reg_write, mem_req, mem_write, adr_src  out  1 each  datapath enables and selects.
- alu_src_a, alu_src_b, result_src  out  2 each  mux selects.
- imm_src  out  3  immediate format.
- alu_ctrl  out  ALU_CTRL_W  ALU operation.
- fault  out  1  FSM is in the FAULT state.
- state_o  out  4  current state encoding, for debug.

## Operation
- Mux select encodings:
  - alu_src_a: 00 = PC, 01 = oldPC, 10 = rs1.
  - alu_src_b: 00 = rs2, 01 = imm, 10 = constant 4.
  - result_src: 00 = ALUOut, 01 = Data, 10 = ALUResult.
  - adr_src: 0 = PC, 1 = result.
- imm_src is decoded combinationally from op in every state: I = 000, S = 001, B = 010, J = 011.
- alu_ctrl encodings: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9. Upper bits are zero-extended.
- States and their encodings. Unlisted outputs are 0; alu_ctrl defaults to add.
  - FETCH (0): adr_src 0, mem_req 1, a 00, b 10, result_src 10. ir_write = pc_write = mem_ready. Go to DECODE on mem_ready.
  - DECODE (1): a 01, b 01 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECR.
    - 0010011: EXECI.
    - 1100011: BRANCH.
    - 1101111: JAL.
    - 1100111: JALR.
    - anything else: FAULT.
  - MEMADR (2): a 10, b 01. Go to MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD (3): adr_src 1, result_src 00, mem_req 1. Go to MEMWB on mem_ready.
  - MEMWB (4): result_src 01, reg_write 1. Go to FETCH.
  - MEMWRITE (5): adr_src 1, result_src 00, mem_req 1, mem_write 1. Go to FETCH on mem_ready.
  - EXECR (6): a 10, b 00, alu_ctrl decoded. Go to ALUWB.
  - EXECI (7): a 10, b 01, alu_ctrl decoded. Go to ALUWB.
  - ALUWB (8): result_src 00, reg_write 1. Go to FETCH.
  - BRANCH (9): a 10, b 00, sub, result_src 00, pc_write = taken. Go to FETCH. If func3 is 010 or 011, go to FAULT with pc_write 0.
  - JAL (10): a 01, b 10, result_src 00, pc_write 1. Go to ALUWB.
  - JALR (11): a 10, b 01, result_src 10, pc_write 1. Go to JLINK.
  - JLINK (12): a 01, b 10, result_src 10, reg_write 1. Go to FETCH.
  - FAULT (13): all enables 0, fault 1. Sticky until reset.
- Branch taken condition by func3:
  - 000: zero.
  - 001: !zero.
  - 100: lt.
  - 101: !lt.
  - 110: ltu.
  - 111: !ltu.
- ALU decode by func3:
  - 000: sub if EXECR and func7_5, otherwise add.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: sra if func7_5, otherwise srl (R-type and I-type alike).
  - 110: or.
  - 111: and.
- Wait counter:
  - Width is $clog2(WAIT_LIMIT+1).
  - Increments each cycle a mem_req state sees mem_ready = 0.
  - Clears on every state change.
  - When it equals WAIT_LIMIT (WAIT_LIMIT > 0) and mem_ready is still 0, the next state is FAULT.
  - mem_ready in the same cycle wins over the timeout.
- Unused state encodings 14 and 15 go to FAULT.

## Timing
- Reset: state = FETCH and counter = 0 asynchronously. While reset is high, every output is forced to 0, including mem_req and state_o.
- The first mem_req is asserted in the first cycle after reset deasserts.
- Outputs are combinational from the registered state plus mem_ready (FETCH) and the flags (BRANCH). There is no output register.
- Cycles per instruction, with zero-wait memory:
  - load: 5.
  - store: 4.
  - R-type and I-type ALU: 4.
  - branch: 3.
  - jal: 4.
  - jalr: 4.
- Each memory wait cycle adds 1 cycle.
- Reset asserted mid-instruction aborts it; no write enable is seen after the reset edge.

## Test plan
- Reset high then low: all outputs 0 while high. Next cycle shows state_o 0 and mem_req 1. With mem_ready = 1, ir_write and pc_write are 1, then state_o = 1.
- Load (op 0000011), mem_ready always 1: state sequence 0,1,2,3,4,0. reg_write = 1 only in state 4, with result_src 01.
- R-type sub (op 0110011, func3 000, func7_5 1): alu_ctrl 1 in EXECR. sra (func3 101, func7_5 1): alu_ctrl 9. I-type addi with func7_5 1: alu_ctrl 0.
- Branches in BRANCH:
  - bne with zero = 1: pc_write 0.
  - bltu with ltu = 1: pc_write 1.
  - func3 010: state 13 next, fault = 1 and held.
- Memory timeout with WAIT_LIMIT = 3: hold mem_ready = 0 in MEMREAD and FAULT is reached after 4 cycles. Asserting mem_ready on the 4th cycle instead goes to MEMWB.
- Illegal opcode 0000000 in DECODE goes to FAULT. Reset mid-FAULT returns to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit.
// A Moore FSM walks each instruction through fetch, decode, execute, memory
// and writeback for a shared-memory datapath. Memory accesses wait on
// mem_ready, with an optional stall limit. Illegal encodings and stall
// timeouts park the FSM in a sticky FAULT state that only reset clears.
// Outputs are decoded from the registered state. They are gated to zero
// while reset is high.
module multicycle_ctrl #(
    parameter int ALU_CTRL_W = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            func3,
    input  logic                  func7_5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  fault,
    output logic [3:0]            state_o
);

    // A zero limit still needs a 1-bit counter so the declaration stays legal.
    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_LIMIT);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JLINK    = 4'd12,
        S_FAULT    = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic       taken;
    logic [3:0] alu_dec;
    logic [2:0] imm_dec;
    logic       timeout;
    logic       mem_state;

    logic       pc_write_c, ir_write_c, reg_write_c, mem_req_c, mem_write_c, adr_src_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
    logic [3:0] alu_op_c;
    logic       fault_c;

    // Instruction-field decode: branch condition, ALU operation and immediate format.
    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase

        alu_dec = ALU_ADD;
        case (func3)
            3'b000:  alu_dec = (state_q == S_EXECR && func7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = func7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase

        imm_dec = 3'b000;
        case (op)
            7'b0100011: imm_dec = 3'b001;
            7'b1100011: imm_dec = 3'b010;
            7'b1101111: imm_dec = 3'b011;
            default:    imm_dec = 3'b000;
        endcase
    end

    // Per-state datapath controls and next-state selection.
    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        result_src_c = 2'b00;
        alu_op_c     = ALU_ADD;
        fault_c      = 1'b0;
        mem_state    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        // A ready in the same cycle takes priority over the stall limit.
        timeout      = (WAIT_LIMIT > 0) && (wait_cnt_q == WAIT_MAX) && !mem_ready;

        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    default:                state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                mem_req_c = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = alu_dec;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = alu_dec;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = ALU_SUB;
                // func3 010/011 are not branch encodings in RV32I.
                if (func3 == 3'b010 || func3 == 3'b011) begin
                    state_d = S_FAULT;
                end else begin
                    pc_write_c = taken;
                    state_d    = S_FETCH;
                end
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_c  = 2'b10;
                alu_src_b_c  = 2'b01;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
                state_d      = S_JLINK;
            end
            S_JLINK: begin
                alu_src_a_c  = 2'b01;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_FAULT: begin
                fault_c = 1'b1;
                state_d = S_FAULT;
            end
            default: state_d = S_FAULT;
        endcase

        // The stall count is per access, so it restarts whenever the state moves.
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_state && !mem_ready && (WAIT_LIMIT > 0) && (wait_cnt_q != WAIT_MAX))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        else
            wait_cnt_d = wait_cnt_q;
    end

    // State and stall-counter registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are forced low during reset so no enable leaks past the reset edge.
    always_comb begin
        pc_write   = !reset && pc_write_c;
        ir_write   = !reset && ir_write_c;
        reg_write  = !reset && reg_write_c;
        mem_req    = !reset && mem_req_c;
        mem_write  = !reset && mem_write_c;
        adr_src    = !reset && adr_src_c;
        alu_src_a  = reset ? 2'b00 : alu_src_a_c;
        alu_src_b  = reset ? 2'b00 : alu_src_b_c;
        result_src = reset ? 2'b00 : result_src_c;
        imm_src    = reset ? 3'b000 : imm_dec;
        alu_ctrl   = reset ? '0 : ALU_CTRL_W'(alu_op_c);
        fault      = !reset && fault_c;
        state_o    = reset ? 4'd0 : state_q;
    end

endmodule
